// File: rtl/sync_fifo_pkg.sv
// Shared defaults and FSM encoding for the SyncFIFO write-side logic.
package sync_fifo_pkg;

    localparam int DEF_BITWIDTH = 5;
    localparam int DEF_DEPTH    = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: searches base+1 upward with wrap, base itself last.
module rr_arbiter #(
    parameter int  NUMREQ = 4,
    localparam int PW     = $clog2(NUMREQ)
) (
    input  logic [NUMREQ-1:0] req,
    input  logic [PW-1:0]     base,
    output logic [NUMREQ-1:0] gnt,
    output logic [PW-1:0]     win,
    output logic              valid
);

    int idx;

    always_comb begin
        gnt   = '0;
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUMREQ; k++) begin
            idx = (int'(base) + k) % NUMREQ;
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                win      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/sync_fifo_write_arbiter.sv
// Shares one SyncFIFO write port among NUMREQ producers: round-robin with bounded bursts,
// writing into a full FIFO only when a pop happens in the same cycle.
module sync_fifo_write_arbiter
    import sync_fifo_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int NUMREQ   = 4,
    parameter int MAXBURST = 4,
    localparam int PW      = $clog2(NUMREQ),
    localparam int CW      = $clog2(MAXBURST + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMREQ-1:0]          req,
    input  logic [NUMREQ*BITWIDTH-1:0] reqData,
    output logic [NUMREQ-1:0]          gnt,
    input  logic                       full,
    input  logic                       fifoREn,
    output logic                       wEn,
    output logic [BITWIDTH-1:0]        dIn,
    output logic [PW-1:0]              owner,
    output logic                       ownerValid
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAXBURST);

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_owner, w_owner_next;
    logic [PW-1:0]   r_last_ptr, w_last_ptr_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;

    logic [BITWIDTH-1:0] w_data [NUMREQ];
    logic                w_space;
    logic                w_owner_elig;
    logic [PW-1:0]       w_base;
    logic [NUMREQ-1:0]   w_rr_gnt;
    logic [PW-1:0]       w_rr_win;
    logic                w_rr_valid;
    logic [NUMREQ-1:0]   w_gnt;
    logic [PW-1:0]       w_win;
    logic                w_owner_path;
    logic                w_wen;

    for (genvar gi = 0; gi < NUMREQ; gi++) begin : g_unpack
        assign w_data[gi] = reqData[gi*BITWIDTH +: BITWIDTH];
    end

    assign w_space      = ~full | fifoREn;
    assign w_owner_elig = (r_state == ST_BURST) & req[r_owner] & (r_cnt < MAX_CNT);
    // Searching from the owner during a burst puts the owner last in the rotation.
    assign w_base       = (r_state == ST_BURST) ? r_owner : r_last_ptr;

    rr_arbiter #(.NUMREQ(NUMREQ)) u_rr (
        .req   (req),
        .base  (w_base),
        .gnt   (w_rr_gnt),
        .win   (w_rr_win),
        .valid (w_rr_valid)
    );

    always_comb begin
        w_gnt        = '0;
        w_win        = r_owner;
        w_owner_path = 1'b0;
        if (!rst && w_space) begin
            if (w_owner_elig) begin
                w_gnt[r_owner] = 1'b1;
                w_owner_path   = 1'b1;
            end else if (w_rr_valid) begin
                w_gnt = w_rr_gnt;
                w_win = w_rr_win;
            end
        end
    end

    assign w_wen      = |w_gnt;
    assign gnt        = w_gnt;
    assign wEn        = w_wen;
    assign dIn        = w_wen ? w_data[w_win] : '0;
    assign owner      = r_owner;
    assign ownerValid = !rst && (r_state == ST_BURST);

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_last_ptr_next = r_last_ptr;
        w_cnt_next      = r_cnt;
        if (w_space) begin
            if (w_wen) begin
                if (w_owner_path) begin
                    w_cnt_next = r_cnt + CW'(1);
                end else begin
                    w_owner_next = w_win;
                    w_cnt_next   = CW'(1);
                    w_state_next = ST_BURST;
                    if (r_state == ST_BURST) begin
                        w_last_ptr_next = r_owner;
                    end
                end
                if (w_cnt_next == MAX_CNT) begin
                    w_state_next    = ST_IDLE;
                    w_last_ptr_next = w_owner_next;
                end
            end else if ((r_state == ST_BURST) && !req[r_owner]) begin
                w_state_next    = ST_IDLE;
                w_last_ptr_next = r_owner;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_last_ptr <= PW'(NUMREQ - 1);
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_last_ptr <= w_last_ptr_next;
            r_cnt      <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// Directed bench for sync_fifo_write_arbiter with BITWIDTH=5, NUMREQ=4, MAXBURST=4.
module tb_sync_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] reqData;
    logic [3:0]  gnt;
    logic        full;
    logic        fifoREn;
    logic        wEn;
    logic [4:0]  dIn;
    logic [1:0]  owner;
    logic        ownerValid;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo_write_arbiter #(.BITWIDTH(5), .NUMREQ(4), .MAXBURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .reqData    (reqData),
        .gnt        (gnt),
        .full       (full),
        .fifoREn    (fifoREn),
        .wEn        (wEn),
        .dIn        (dIn),
        .owner      (owner),
        .ownerValid (ownerValid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [4:0] v);
        reqData[i*5 +: 5] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; full = 1'b0; fifoREn = 1'b0; reqData = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; full = 1'b0; fifoREn = 1'b0; reqData = '0;
        step();
        step();
        #1;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
        n_checks++; if (wEn !== 1'b0) $display("FAIL reset_wEn: got %b want 0", wEn); else n_pass++;
        n_checks++; if (dIn !== 5'd0) $display("FAIL reset_dIn: got %0d want 0", dIn); else n_pass++;
        n_checks++; if (ownerValid !== 1'b0) $display("FAIL reset_ownerValid: got %b want 0", ownerValid); else n_pass++;
        n_checks++; if (owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", owner); else n_pass++;
        req = 4'b1111;
        #1;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt_with_req: got %b want 0000", gnt); else n_pass++;
        $display("test_reset done");
        step();
    endtask

    task automatic test_single();
        rst = 1'b0; req = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            set_data(0, 5'(k));
            #1;
            n_checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt[%0d]: got %b want 0001", k, gnt); else n_pass++;
            n_checks++; if (dIn !== 5'(k)) $display("FAIL single_dIn[%0d]: got %0d want %0d", k, dIn, k); else n_pass++;
            step();
            n_checks++; if (owner !== 2'd0) $display("FAIL single_owner[%0d]: got %0d want 0", k, owner); else n_pass++;
            n_checks++; if (ownerValid !== ((k % 4) != 0)) $display("FAIL single_ownerValid[%0d]: got %b want %b", k, ownerValid, ((k % 4) != 0)); else n_pass++;
            $display("single write %0d: gnt=%b dIn=%0d", k, gnt, dIn);
        end
        req = '0;
    endtask

    task automatic test_fairness();
        int cnt [4];
        int p;
        do_reset();
        full = 1'b1; fifoREn = 1'b1; req = 4'b1111;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 20; c++) begin
            p = (c / 4) % 4;
            for (int i = 0; i < 4; i++) set_data(i, 5'(i * 8 + cnt[i]));
            #1;
            n_checks++; if (gnt !== 4'(1 << p)) $display("FAIL fair_gnt[%0d]: got %b want %b", c, gnt, 4'(1 << p)); else n_pass++;
            n_checks++; if (dIn !== 5'(p * 8 + cnt[p])) $display("FAIL fair_dIn[%0d]: got %0d want %0d", c, dIn, p * 8 + cnt[p]); else n_pass++;
            $display("fair cycle %0d: gnt=%b dIn=%0d", c, gnt, dIn);
            cnt[p]++;
            step();
        end
        req = '0; full = 1'b0; fifoREn = 1'b0;
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0011;
        set_data(0, 5'd3);
        set_data(1, 5'd17);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (gnt !== 4'b0001) $display("FAIL early_p0_gnt[%0d]: got %b want 0001", c, gnt); else n_pass++;
            step();
        end
        req = 4'b0010;
        #1;
        n_checks++; if (gnt !== 4'b0010) $display("FAIL early_handover_gnt: got %b want 0010", gnt); else n_pass++;
        n_checks++; if (dIn !== 5'd17) $display("FAIL early_handover_dIn: got %0d want 17", dIn); else n_pass++;
        step();
        n_checks++; if (owner !== 2'd1) $display("FAIL early_owner: got %0d want 1", owner); else n_pass++;
        n_checks++; if (ownerValid !== 1'b1) $display("FAIL early_ownerValid: got %b want 1", ownerValid); else n_pass++;
        req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (gnt !== 4'b0010) $display("FAIL early_p1_gnt[%0d]: got %b want 0010", c, gnt); else n_pass++;
            step();
        end
        #1;
        n_checks++; if (gnt !== 4'b0001) $display("FAIL early_back_to_p0_gnt: got %b want 0001", gnt); else n_pass++;
        n_checks++; if (dIn !== 5'd3) $display("FAIL early_back_to_p0_dIn: got %0d want 3", dIn); else n_pass++;
        $display("early release: back to p0 gnt=%b dIn=%0d", gnt, dIn);
        step();
        req = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b0100;
        set_data(2, 5'd21);
        #1;
        n_checks++; if (gnt !== 4'b0100) $display("FAIL stall_first_gnt: got %b want 0100", gnt); else n_pass++;
        step();
        full = 1'b1; fifoREn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (gnt !== 4'b0000) $display("FAIL stall_gnt[%0d]: got %b want 0000", c, gnt); else n_pass++;
            n_checks++; if (wEn !== 1'b0) $display("FAIL stall_wEn[%0d]: got %b want 0", c, wEn); else n_pass++;
            n_checks++; if (dIn !== 5'd0) $display("FAIL stall_dIn[%0d]: got %0d want 0", c, dIn); else n_pass++;
            step();
            n_checks++; if (owner !== 2'd2) $display("FAIL stall_owner[%0d]: got %0d want 2", c, owner); else n_pass++;
            n_checks++; if (ownerValid !== 1'b1) $display("FAIL stall_ownerValid[%0d]: got %b want 1", c, ownerValid); else n_pass++;
        end
        fifoREn = 1'b1;
        #1;
        n_checks++; if (gnt !== 4'b0100) $display("FAIL pop_gnt: got %b want 0100", gnt); else n_pass++;
        n_checks++; if (wEn !== 1'b1) $display("FAIL pop_wEn: got %b want 1", wEn); else n_pass++;
        n_checks++; if (dIn !== 5'd21) $display("FAIL pop_dIn: got %0d want 21", dIn); else n_pass++;
        $display("full with pop: gnt=%b wEn=%b dIn=%0d", gnt, wEn, dIn);
        step();
        full = 1'b0; fifoREn = 1'b0; req = 4'b0101;
        set_data(0, 5'd9);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (gnt !== 4'b0100) $display("FAIL stall_cnt_gnt[%0d]: got %b want 0100", c, gnt); else n_pass++;
            step();
        end
        #1;
        n_checks++; if (gnt !== 4'b0001) $display("FAIL stall_handover_gnt: got %b want 0001", gnt); else n_pass++;
        n_checks++; if (dIn !== 5'd9) $display("FAIL stall_handover_dIn: got %0d want 9", dIn); else n_pass++;
        step();
        req = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0100;
        set_data(0, 5'd5);
        set_data(2, 5'd22);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (gnt !== 4'b0100) $display("FAIL midrst_pre_gnt[%0d]: got %b want 0100", c, gnt); else n_pass++;
            step();
        end
        rst = 1'b1;
        #1;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL midrst_gnt: got %b want 0000", gnt); else n_pass++;
        n_checks++; if (wEn !== 1'b0) $display("FAIL midrst_wEn: got %b want 0", wEn); else n_pass++;
        n_checks++; if (ownerValid !== 1'b0) $display("FAIL midrst_ownerValid: got %b want 0", ownerValid); else n_pass++;
        step();
        rst = 1'b0; req = 4'b1101;
        #1;
        n_checks++; if (owner !== 2'd0) $display("FAIL midrst_owner: got %0d want 0", owner); else n_pass++;
        n_checks++; if (gnt !== 4'b0001) $display("FAIL midrst_after_gnt: got %b want 0001", gnt); else n_pass++;
        n_checks++; if (dIn !== 5'd5) $display("FAIL midrst_after_dIn: got %0d want 5", dIn); else n_pass++;
        $display("reset mid-burst: first grant gnt=%b dIn=%0d", gnt, dIn);
        step();
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_early_release();
        test_full_stall();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
